// File: rtl/rob_param_queue.sv
// rtl/rob_param_queue.sv - parametrised reorder buffer with multi-channel writeback and query forwarding
// In-order allocate and commit, out-of-order completion; a mispredict flushes on its own commit edge.
module rob_param_queue #(
    parameter int DEPTH  = 8,
    parameter int ID_W   = $clog2(DEPTH),
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int N_WB   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    output logic [ID_W-1:0]          alloc_id,
    input  logic [6:0]               alloc_opcode,
    input  logic [4:0]               alloc_rd,
    input  logic [ADDR_W-1:0]        alloc_pc,
    input  logic                     alloc_pred,
    input  logic                     alloc_done,
    input  logic [DATA_W-1:0]        alloc_data,
    input  logic [N_WB-1:0]          wb_valid,
    input  logic [N_WB*ID_W-1:0]     wb_id,
    input  logic [N_WB*DATA_W-1:0]   wb_data,
    input  logic [N_WB-1:0]          wb_taken,
    input  logic [N_WB*ADDR_W-1:0]   wb_target,
    input  logic [ID_W-1:0]          qry1_id,
    output logic                     qry1_ready,
    output logic [DATA_W-1:0]        qry1_data,
    input  logic [ID_W-1:0]          qry2_id,
    output logic                     qry2_ready,
    output logic [DATA_W-1:0]        qry2_data,
    output logic                     commit_reg_valid,
    output logic [4:0]               commit_rd,
    output logic [DATA_W-1:0]        commit_data,
    output logic [ID_W-1:0]          commit_id,
    output logic                     commit_store,
    output logic                     br_valid,
    output logic [ADDR_W-1:0]        br_pc,
    output logic                     br_taken,
    output logic                     flush,
    output logic [ADDR_W-1:0]        redirect_pc,
    output logic [ID_W:0]            count
);
    localparam logic [6:0]    OPCODE_S    = 7'b0100011;
    localparam logic [6:0]    OPCODE_B    = 7'b1100011;
    localparam logic [6:0]    OPCODE_JALR = 7'b1100111;
    localparam logic [ID_W:0] FULL        = DEPTH[ID_W:0];

    logic [ID_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [ID_W:0]     count_q, count_d;
    logic [DEPTH-1:0]  busy_q, busy_d, done_q, done_d;
    logic [DEPTH-1:0]  pred_q, pred_d, taken_q, taken_d;
    logic [6:0]        op_q   [DEPTH];
    logic [6:0]        op_d   [DEPTH];
    logic [4:0]        rd_q   [DEPTH];
    logic [4:0]        rd_d   [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];
    logic [ADDR_W-1:0] tgt_q  [DEPTH];
    logic [ADDR_W-1:0] tgt_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic              creg_q, creg_d, cstore_q, cstore_d, brv_q, brv_d, flush_q, flush_d;
    logic              brtk_q, brtk_d;
    logic [4:0]        crd_q, crd_d;
    logic [DATA_W-1:0] cdata_q, cdata_d;
    logic [ID_W-1:0]   cid_q, cid_d;
    logic [ADDR_W-1:0] brpc_q, brpc_d, redir_q, redir_d;

    logic [ID_W-1:0]   wid  [N_WB];
    logic [DATA_W-1:0] wdat [N_WB];
    logic [ADDR_W-1:0] wtgt [N_WB];
    logic [ID_W-1:0]   qid  [2];
    logic [1:0]        q_rdy;
    logic [DATA_W-1:0] q_dat [2];
    logic              alloc_fire, commit_fire;

    function automatic logic is_ctl(input logic [6:0] op);
        return (op == OPCODE_B) || (op == OPCODE_JALR);
    endfunction

    always_comb begin
        for (int k = 0; k < N_WB; k++) begin
            wid[k]  = wb_id[k*ID_W +: ID_W];
            wdat[k] = wb_data[k*DATA_W +: DATA_W];
            wtgt[k] = wb_target[k*ADDR_W +: ADDR_W];
        end
    end

    assign alloc_ready = (count_q < FULL);
    assign alloc_id    = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = (count_q != '0) && done_q[head_q];

    assign qid[0] = qry1_id;
    assign qid[1] = qry2_id;

    // A writeback landing this cycle overrides stored data; higher channel index wins.
    always_comb begin
        for (int q = 0; q < 2; q++) begin
            q_rdy[q] = 1'b0;
            q_dat[q] = '0;
            if (busy_q[qid[q]]) begin
                if (done_q[qid[q]]) begin
                    q_rdy[q] = 1'b1;
                    q_dat[q] = data_q[qid[q]];
                end
                for (int k = 0; k < N_WB; k++) begin
                    if (wb_valid[k] && (wid[k] == qid[q])) begin
                        q_rdy[q] = 1'b1;
                        q_dat[q] = wdat[k];
                    end
                end
            end
        end
    end

    assign qry1_ready = q_rdy[0];
    assign qry1_data  = q_dat[0];
    assign qry2_ready = q_rdy[1];
    assign qry2_data  = q_dat[1];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pred_d  = pred_q;
        taken_d = taken_q;
        op_d    = op_q;
        rd_d    = rd_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        data_d  = data_q;
        creg_d   = 1'b0;
        cstore_d = 1'b0;
        brv_d    = 1'b0;
        flush_d  = 1'b0;
        crd_d    = crd_q;
        cdata_d  = cdata_q;
        cid_d    = cid_q;
        brpc_d   = brpc_q;
        brtk_d   = brtk_q;
        redir_d  = redir_q;
        if (rdy) begin
            for (int k = 0; k < N_WB; k++) begin
                if (wb_valid[k] && busy_q[wid[k]]) begin
                    done_d[wid[k]] = 1'b1;
                    data_d[wid[k]] = wdat[k];
                    if (is_ctl(op_q[wid[k]])) begin
                        taken_d[wid[k]] = wb_taken[k];
                        tgt_d[wid[k]]   = wtgt[k];
                    end
                end
            end
            if (alloc_fire) begin
                busy_d[tail_q]  = 1'b1;
                done_d[tail_q]  = alloc_done;
                op_d[tail_q]    = alloc_opcode;
                rd_d[tail_q]    = alloc_rd;
                pc_d[tail_q]    = alloc_pc;
                pred_d[tail_q]  = alloc_pred;
                data_d[tail_q]  = alloc_done ? alloc_data : '0;
                taken_d[tail_q] = 1'b0;
                tgt_d[tail_q]   = '0;
                tail_d          = tail_q + ID_W'(1);
            end
            if (commit_fire) begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                head_d         = head_q + ID_W'(1);
                cid_d          = head_q;
                crd_d          = rd_q[head_q];
                cdata_d        = data_q[head_q];
                case (op_q[head_q])
                    OPCODE_S: cstore_d = 1'b1;
                    OPCODE_B: begin
                        brv_d  = 1'b1;
                        brpc_d = pc_q[head_q];
                        brtk_d = taken_q[head_q];
                        if (taken_q[head_q] != pred_q[head_q]) begin
                            flush_d = 1'b1;
                            redir_d = taken_q[head_q] ? tgt_q[head_q] : pc_q[head_q] + ADDR_W'(4);
                        end
                    end
                    OPCODE_JALR: begin
                        creg_d  = 1'b1;
                        flush_d = 1'b1;
                        redir_d = tgt_q[head_q];
                    end
                    default: creg_d = 1'b1;
                endcase
            end
            count_d = count_q + {{ID_W{1'b0}}, alloc_fire} - {{ID_W{1'b0}}, commit_fire};
            // Flushing on the commit edge also drops this cycle's alloc and writebacks.
            if (flush_d) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                busy_d  = '0;
                done_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            done_q   <= '0;
            pred_q   <= '0;
            taken_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                rd_q[i]   <= '0;
                pc_q[i]   <= '0;
                tgt_q[i]  <= '0;
                data_q[i] <= '0;
            end
            creg_q   <= 1'b0;
            cstore_q <= 1'b0;
            brv_q    <= 1'b0;
            flush_q  <= 1'b0;
            brtk_q   <= 1'b0;
            crd_q    <= '0;
            cdata_q  <= '0;
            cid_q    <= '0;
            brpc_q   <= '0;
            redir_q  <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pred_q   <= pred_d;
            taken_q  <= taken_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            data_q   <= data_d;
            creg_q   <= creg_d;
            cstore_q <= cstore_d;
            brv_q    <= brv_d;
            flush_q  <= flush_d;
            brtk_q   <= brtk_d;
            crd_q    <= crd_d;
            cdata_q  <= cdata_d;
            cid_q    <= cid_d;
            brpc_q   <= brpc_d;
            redir_q  <= redir_d;
        end
    end

    assign commit_reg_valid = creg_q;
    assign commit_rd        = crd_q;
    assign commit_data      = cdata_q;
    assign commit_id        = cid_q;
    assign commit_store     = cstore_q;
    assign br_valid         = brv_q;
    assign br_pc            = brpc_q;
    assign br_taken         = brtk_q;
    assign flush            = flush_q;
    assign redirect_pc      = redir_q;
    assign count            = count_q;
endmodule
